// File: rtl/seq_cmp_unit.sv
// Multi-cycle set-on-compare unit: SLT/SLTU/SEQ/SNE via a serial A-B, CHUNK bits per cycle.
// Optional SEQ_CMP_EARLY_EXIT_EN: SEQ/SNE finish on the first non-zero difference chunk.
module seq_cmp_unit #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res
);

   localparam int N  = WIDTH / CHUNK;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] OP_SLT  = 2'b00;
   localparam logic [1:0] OP_SLTU = 2'b01;
   localparam logic [1:0] OP_SEQ  = 2'b10;
   localparam logic [1:0] OP_SNE  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [1:0]       op_q, op_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             res_bit_q, res_bit_d;

   logic [CHUNK-1:0] a_chunk, b_chunk, diff;
   logic [CHUNK:0]   sum;
   logic             diff_zero, zero_n, last_chunk;

   // One slice of A + ~B + carry; carry-out of the final slice is the "no borrow" flag.
   always_comb begin
      a_chunk    = a_q[idx_q*CHUNK +: CHUNK];
      b_chunk    = b_q[idx_q*CHUNK +: CHUNK];
      sum        = {1'b0, a_chunk} + {1'b0, ~b_chunk} + {{CHUNK{1'b0}}, carry_q};
      diff       = sum[CHUNK-1:0];
      diff_zero  = (diff == '0);
      zero_n     = zero_q & diff_zero;
      last_chunk = (idx_q == IW'(N - 1));
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      idx_d     = idx_q;
      carry_d   = carry_q;
      zero_d    = zero_q;
      res_bit_d = res_bit_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d     = A;
               b_d     = B;
               op_d    = op;
               carry_d = 1'b1;
               zero_d  = 1'b1;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            carry_d = sum[CHUNK];
            zero_d  = zero_n;
            idx_d   = idx_q + 1'b1;
            if (last_chunk) begin
               idx_d   = '0;
               state_d = S_DONE;
               unique case (op_q)
                  // Differing signs decide SLT directly; equal signs cannot overflow.
                  OP_SLT:  res_bit_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) ? diff[CHUNK-1] : a_q[WIDTH-1];
                  OP_SLTU: res_bit_d = ~sum[CHUNK];
                  OP_SEQ:  res_bit_d = zero_n;
                  OP_SNE:  res_bit_d = ~zero_n;
                  default: res_bit_d = 1'b0;
               endcase
            end
`ifdef SEQ_CMP_EARLY_EXIT_EN
            // Any non-zero slice already settles equality; op_q[0] distinguishes SNE from SEQ.
            if (op_q[1] && !diff_zero) begin
               idx_d     = '0;
               state_d   = S_DONE;
               res_bit_d = op_q[0];
            end
`endif
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         idx_q     <= '0;
         carry_q   <= 1'b1;
         zero_q    <= 1'b1;
         res_bit_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         idx_q     <= idx_d;
         carry_q   <= carry_d;
         zero_q    <= zero_d;
         res_bit_q <= res_bit_d;
      end
   end

   assign res = {{(WIDTH-1){1'b0}}, res_bit_q};

endmodule

// File: doc/seq_cmp_unit.md
Name: seq_cmp_unit

Overview:
- Parametrised, multi-cycle set-on-compare unit for the multi-cycle CPU datapath.
- Evaluates SLT, SLTU, SEQ or SNE on two WIDTH-bit operands.
- Computes A - B serially, CHUNK bits per cycle from LSB to MSB, with carry and zero tracking.
- Returns a WIDTH-bit zero-extended 0/1 result through valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of CHUNK, at least 2.
- CHUNK, 8, bits of A - B evaluated per cycle; N = WIDTH/CHUNK.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  unit can accept operands.
- op  input  2  operation: 00 SLT (signed), 01 SLTU (unsigned), 10 SEQ, 11 SNE.
- A  input  WIDTH  first operand.
- B  input  WIDTH  second operand.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts result.
- res  output  WIDTH  bit 0 = comparison outcome, bits WIDTH-1:1 = 0.

Behaviour:
- Reset, synchronous and active-high, effective at the clock edge:
  - state=IDLE, in_ready=1, out_valid=0, res=0, chunk index=0, carry=1, zero=1.
  - Reset mid-RUN or mid-DONE discards the operation; no result is produced.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch A, B, op; set carry=1, zero=1, idx=0; go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle compute {c, d} = A[idx chunk] + ~B[idx chunk] + carry.
    - Store c into carry.
    - zero &= (d==0).
    - On the MSB chunk, also latch d's top bit as S_msb.
    - idx increments; after chunk N-1 go to DONE.
  - DONE: out_valid=1 and res held stable until out_ready. On out_valid&out_ready, go to IDLE, out_valid=0.
- Result rules, formed on entry to DONE:
  - SLT: if A[msb]==B[msb] then S_msb, else A[msb].
  - SLTU: ~carry (borrow).
  - SEQ: zero.
  - SNE: ~zero.
- Latency: accept at edge T0; out_valid=1 after edge T0+N. Throughput is one op per N+2 cycles minimum (IDLE re-entry costs a cycle). No bypass of IDLE.
- Inputs A/B/op are ignored outside the IDLE acceptance cycle. Changing them during RUN has no effect.
- in_valid while busy is not consumed; the producer must hold it.
- out_ready while out_valid=0 is ignored.
- Boundaries:
  - A==B gives SLT=0, SLTU=0, SEQ=1.
  - A=most negative, B=most positive gives SLT=1, SLTU=0.
  - CHUNK==WIDTH gives N=1 and one RUN cycle.

Optional Feature:
- Macro SEQ_CMP_EARLY_EXIT_EN.
- When defined: in RUN with op SEQ/SNE, a chunk with d!=0 moves directly to DONE (SEQ res=0, SNE res=1), skipping remaining chunks. Latency for SEQ/SNE = index of first differing chunk + 1 cycles. SLT/SLTU are unchanged.
- When undefined: all ops take exactly N RUN cycles.

Test Plan:
- SLT, A=0xFFFFFFFF(-1), B=0x00000001, WIDTH=32/CHUNK=8 -> out_valid exactly 4 cycles after acceptance, res=0x00000001. Same operands with SLTU -> res=0.
- SLT, A=0x7FFFFFFF, B=0x80000000 -> res=0. SLTU with the same operands -> res=1. SLT with A=0x80000000, B=0x7FFFFFFF -> res=1.
- SEQ/SNE, A=B=0x12345678 -> SEQ res=1, SNE res=0. SEQ with A=0x12345679, B=0x12345678 -> res=0 (with SEQ_CMP_EARLY_EXIT_EN: out_valid 1 cycle after acceptance, otherwise 4).
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> res and out_valid stable, in_ready=0. A new in_valid is not accepted until the cycle after the out handshake.
- Reset mid-RUN: assert rst after the 2nd chunk -> next edge gives state IDLE, out_valid=0, in_ready=1, res=0. A following SLTU with A=3, B=5 yields res=1 normally.
- Parameter sweep WIDTH=16/CHUNK=16 and WIDTH=16/CHUNK=4 with A=0x8000, B=0x0001 -> SLT=1, SLTU=0. Latency 1 and 4 cycles respectively.
